// File: rtl/qclk_pkg.sv
// Shared qclk definitions: default widths, command record and head classification.
package qclk_pkg;
    localparam int QCLK_WIDTH  = 32;
    localparam int QCLK_DATA_W = 16;

    typedef struct packed {
        logic [QCLK_WIDTH-1:0]  ts;
        logic [QCLK_DATA_W-1:0] data;
    } qclk_cmd_t;

    typedef enum logic [1:0] {
        HEAD_EMPTY,
        HEAD_WAIT,
        HEAD_MATCH,
        HEAD_LATE
    } head_state_e;
endpackage

// File: rtl/qclk_trig_if.sv
// Command-in / trigger-out bundle for qclk_trig.
interface qclk_trig_if
    import qclk_pkg::*;
#(
    parameter int WIDTH  = QCLK_WIDTH,
    parameter int DATA_W = QCLK_DATA_W,
    parameter int DEPTH  = 4
);
    logic [WIDTH-1:0]        qclk_in;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [WIDTH-1:0]        cmd_time;
    logic [DATA_W-1:0]       cmd_data;
    logic                    flush;
    logic                    trig_valid;
    logic [DATA_W-1:0]       trig_data;
    logic [$clog2(DEPTH):0]  count;
    logic                    late_err;
    logic                    late_flag;
    logic                    late_clear;

    modport master (
        output qclk_in, cmd_valid, cmd_time, cmd_data, flush, late_clear,
        input  cmd_ready, trig_valid, trig_data, count, late_err, late_flag
    );

    modport slave (
        input  qclk_in, cmd_valid, cmd_time, cmd_data, flush, late_clear,
        output cmd_ready, trig_valid, trig_data, count, late_err, late_flag
    );
endinterface

// File: rtl/qclk_cmd_fifo.sv
// Command queue storage: synchronous push/pop/flush, head always visible, entry count.
module qclk_cmd_fifo
    import qclk_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type cmd_t = qclk_cmd_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  cmd_t                   push_cmd,
    input  logic                   pop,
    output cmd_t                   head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cmd_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_cmd;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/qclk_trig.sv
// qclk_trig: fires queued commands when qclk_in reaches the head's time stamp.
// QCLK_TRIG_LATE_DROP_EN: drop late heads and report them on late_err / late_flag.
module qclk_trig
    import qclk_pkg::*;
#(
    parameter int WIDTH  = QCLK_WIDTH,
    parameter int DATA_W = QCLK_DATA_W,
    parameter int DEPTH  = 4
) (
    input logic        clk,
    input logic        reset,
    qclk_trig_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Same layout as qclk_cmd_t, sized to this instance's parameters.
    typedef struct packed {
        logic [WIDTH-1:0]  ts;
        logic [DATA_W-1:0] data;
    } cmd_t;

    cmd_t              head;
    cmd_t              push_cmd;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  delta;
    head_state_e       head_state;
    logic              push;
    logic              fire;
    logic              late_pop;
    logic              trig_valid_q;
    logic [DATA_W-1:0] trig_data_q;

    assign push_cmd.ts   = bus.cmd_time;
    assign push_cmd.data = bus.cmd_data;
    assign bus.cmd_ready = (count != CW'(DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready && !bus.flush;

    // Modular difference: MSB set means the head time is already behind qclk_in.
    assign delta = head.ts - bus.qclk_in;

    always_comb begin
        head_state = HEAD_EMPTY;
        if (count != '0) begin
            if (delta == '0)          head_state = HEAD_MATCH;
            else if (delta[WIDTH-1])  head_state = HEAD_LATE;
            else                      head_state = HEAD_WAIT;
        end
    end

    assign fire = (head_state == HEAD_MATCH) && !bus.flush;

`ifdef QCLK_TRIG_LATE_DROP_EN
    assign late_pop = (head_state == HEAD_LATE) && !bus.flush;
`else
    assign late_pop = 1'b0;
`endif

    qclk_cmd_fifo #(
        .DEPTH (DEPTH),
        .cmd_t (cmd_t)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (bus.flush),
        .push     (push),
        .push_cmd (push_cmd),
        .pop      (fire || late_pop),
        .head     (head),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_valid_q <= 1'b0;
            trig_data_q  <= '0;
        end else begin
            trig_valid_q <= fire;
            if (fire) trig_data_q <= head.data;
        end
    end

    assign bus.trig_valid = trig_valid_q;
    assign bus.trig_data  = trig_data_q;
    assign bus.count      = count;

`ifdef QCLK_TRIG_LATE_DROP_EN
    logic late_err_q;
    logic late_flag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            late_err_q  <= 1'b0;
            late_flag_q <= 1'b0;
        end else begin
            late_err_q <= late_pop;
            if (bus.late_clear)  late_flag_q <= 1'b0;
            else if (late_pop)   late_flag_q <= 1'b1;
        end
    end

    assign bus.late_err  = late_err_q;
    assign bus.late_flag = late_flag_q;
`else
    logic unused_late_clear;
    assign unused_late_clear = bus.late_clear;
    assign bus.late_err      = 1'b0;
    assign bus.late_flag     = 1'b0;
`endif
endmodule

// File: tb/tb_qclk_trig.sv
// Self-checking bench for qclk_trig; reference model is a queue of pending commands.
module tb_qclk_trig;
    import qclk_pkg::*;

    localparam int WIDTH  = 32;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
`ifdef QCLK_TRIG_LATE_DROP_EN
    localparam bit LATE_DROP = 1'b1;
`else
    localparam bit LATE_DROP = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0]  ts;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    qclk_trig_if #(.WIDTH(WIDTH), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    qclk_trig #(.WIDTH(WIDTH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ent_t              q[$];
    logic              exp_tv = 1'b0;
    logic [DATA_W-1:0] exp_td = '0;
    logic              exp_le = 1'b0;
    logic              exp_lf = 1'b0;
    int                n_tests = 0;
    int                n_fail  = 0;

    // One clock of the reference behaviour, using the inputs as they stand now.
    task automatic model_step();
        int               sz;
        logic [WIDTH-1:0] diff;
        bit               late_set;
        ent_t             e;
        sz       = q.size();
        late_set = 1'b0;
        if (reset) begin
            q.delete();
            exp_tv = 1'b0; exp_td = '0; exp_le = 1'b0; exp_lf = 1'b0;
            return;
        end
        exp_tv = 1'b0;
        exp_le = 1'b0;
        if (bus.flush) begin
            q.delete();
        end else begin
            if (sz > 0) begin
                diff = q[0].ts - bus.qclk_in;
                if (diff == 0) begin
                    exp_tv = 1'b1;
                    exp_td = q[0].data;
                    void'(q.pop_front());
                end else if (LATE_DROP && $signed(diff) < 0) begin
                    exp_le   = 1'b1;
                    late_set = 1'b1;
                    void'(q.pop_front());
                end
            end
            if (bus.cmd_valid && sz < DEPTH) begin
                e.ts = bus.cmd_time; e.data = bus.cmd_data;
                q.push_back(e);
            end
        end
        if (LATE_DROP) exp_lf = bus.late_clear ? 1'b0 : (late_set ? 1'b1 : exp_lf);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] t, input logic [DATA_W-1:0] d);
        bus.cmd_valid = v;
        bus.cmd_time  = t;
        bus.cmd_data  = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_tests++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.cmd_ready); end
        n_tests++; if (bus.trig_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tv got %b want 0", bus.trig_valid); end
        n_tests++; if (bus.trig_data !== 16'h0) begin n_fail++; $display("FAIL reset_td got %h want 0", bus.trig_data); end
        n_tests++; if (bus.late_err !== 1'b0) begin n_fail++; $display("FAIL reset_le got %b want 0", bus.late_err); end
        n_tests++; if (bus.late_flag !== 1'b0) begin n_fail++; $display("FAIL reset_lf got %b want 0", bus.late_flag); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int fired_at = -1;
        bus.qclk_in = 32'd90;
        drive(1'b1, 32'd100, 16'hA5);
        tick();
        drive(1'b0, '0, '0);
        for (int i = 0; i < 15; i++) begin
            bus.qclk_in = 32'd91 + 32'(i);
            tick();
            n_tests++; if (bus.trig_valid !== exp_tv) begin n_fail++; $display("FAIL single_tv qclk=%0d got %b want %b", bus.qclk_in, bus.trig_valid, exp_tv); end
            n_tests++; if (bus.count !== 3'(q.size())) begin n_fail++; $display("FAIL single_count got %0d want %0d", bus.count, q.size()); end
            if (bus.trig_valid === 1'b1) fired_at = int'(bus.qclk_in);
        end
        n_tests++; if (fired_at != 100) begin n_fail++; $display("FAIL single_time fired after qclk=%0d want 100", fired_at); end
        n_tests++; if (bus.trig_data !== 16'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", bus.trig_data); end
        n_tests++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL single_empty got %0d want 0", bus.count); end
    endtask

    task automatic test_full();
        logic [DATA_W-1:0] dat [4];
        int nf = 0;
        bus.qclk_in = 32'd190;
        for (int i = 0; i < 4; i++) begin
            dat[i] = 16'($urandom);
            drive(1'b1, 32'd200 + 32'(i), dat[i]);
            tick();
        end
        n_tests++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", bus.cmd_ready); end
        drive(1'b1, 32'd204, 16'hDEAD);
        tick();
        drive(1'b0, '0, '0);
        n_tests++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL full_fifth got count %0d want 4", bus.count); end
        for (int i = 0; i < 20; i++) begin
            bus.qclk_in = 32'd191 + 32'(i);
            tick();
            n_tests++; if (bus.trig_valid !== exp_tv) begin n_fail++; $display("FAIL full_tv qclk=%0d got %b want %b", bus.qclk_in, bus.trig_valid, exp_tv); end
            if (bus.trig_valid === 1'b1) begin
                n_tests++;
                if (nf >= 4 || bus.qclk_in !== 32'd200 + 32'(nf) || bus.trig_data !== dat[nf]) begin
                    n_fail++;
                    $display("FAIL full_order fire %0d at qclk=%0d data %h want qclk=%0d", nf, bus.qclk_in, bus.trig_data, 200 + nf);
                end
                nf++;
            end
        end
        n_tests++; if (nf != 4) begin n_fail++; $display("FAIL full_fires got %0d want 4", nf); end
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] d;
        logic [WIDTH-1:0]  fired_at = '0;
        bit                fired    = 1'b0;
        d = 16'($urandom);
        bus.qclk_in = 32'hFFFF_FFFE;
        drive(1'b1, 32'h0000_0001, d);
        tick();
        drive(1'b0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            bus.qclk_in = bus.qclk_in + 32'd1;
            tick();
            n_tests++; if (bus.late_err !== 1'b0) begin n_fail++; $display("FAIL wrap_late got %b want 0", bus.late_err); end
            if (bus.trig_valid === 1'b1) begin fired = 1'b1; fired_at = bus.qclk_in; end
        end
        n_tests++; if (!fired || fired_at !== 32'd1) begin n_fail++; $display("FAIL wrap_fire fired=%0d at qclk=%h want 1", fired, fired_at); end
        n_tests++; if (bus.trig_data !== d) begin n_fail++; $display("FAIL wrap_data got %h want %h", bus.trig_data, d); end
    endtask

`ifdef QCLK_TRIG_LATE_DROP_EN
    task automatic test_late();
        bus.qclk_in = 32'd60;
        drive(1'b1, 32'd50, 16'h1234);
        tick();
        drive(1'b0, '0, '0);
        tick();
        n_tests++; if (bus.late_err !== 1'b1) begin n_fail++; $display("FAIL late_err got %b want 1", bus.late_err); end
        n_tests++; if (bus.late_flag !== 1'b1) begin n_fail++; $display("FAIL late_flag got %b want 1", bus.late_flag); end
        n_tests++; if (bus.trig_valid !== 1'b0) begin n_fail++; $display("FAIL late_tv got %b want 0", bus.trig_valid); end
        n_tests++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL late_count got %0d want 0", bus.count); end
        tick();
        n_tests++; if (bus.late_err !== 1'b0) begin n_fail++; $display("FAIL late_once got %b want 0", bus.late_err); end
        n_tests++; if (bus.late_flag !== 1'b1) begin n_fail++; $display("FAIL late_sticky got %b want 1", bus.late_flag); end
        bus.late_clear = 1'b1;
        tick();
        bus.late_clear = 1'b0;
        n_tests++; if (bus.late_flag !== 1'b0) begin n_fail++; $display("FAIL late_clear got %b want 0", bus.late_flag); end
        drive(1'b1, 32'd50, 16'h5678);
        tick();
        drive(1'b0, '0, '0);
        bus.late_clear = 1'b1;
        tick();
        bus.late_clear = 1'b0;
        n_tests++; if (bus.late_err !== 1'b1) begin n_fail++; $display("FAIL late_prio_err got %b want 1", bus.late_err); end
        n_tests++; if (bus.late_flag !== 1'b0) begin n_fail++; $display("FAIL late_prio_flag got %b want 0", bus.late_flag); end
    endtask
`else
    task automatic test_late();
        bus.qclk_in = 32'd60;
        drive(1'b1, 32'd50, 16'h1234);
        tick();
        drive(1'b0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            bus.qclk_in = 32'd61 + 32'(i);
            bus.late_clear = 1'($urandom);
            tick();
            n_tests++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL hold_count got %0d want 1", bus.count); end
            n_tests++; if (bus.trig_valid !== 1'b0) begin n_fail++; $display("FAIL hold_tv got %b want 0", bus.trig_valid); end
            n_tests++; if (bus.late_err !== 1'b0 || bus.late_flag !== 1'b0) begin n_fail++; $display("FAIL hold_late got %b%b want 00", bus.late_err, bus.late_flag); end
        end
        bus.late_clear = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        n_tests++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL hold_flush got %0d want 0", bus.count); end
    endtask
`endif

    task automatic test_flush();
        bus.qclk_in = 32'd300;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'd310 + 32'(10 * i), 16'($urandom));
            tick();
        end
        drive(1'b0, '0, '0);
        for (int i = 1; i < 10; i++) begin
            bus.qclk_in = 32'd300 + 32'(i);
            tick();
        end
        n_tests++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL flush_pre got %0d want 3", bus.count); end
        bus.qclk_in = 32'd310;
        bus.flush = 1'b1;
        drive(1'b1, 32'd340, 16'hBEEF);
        tick();
        bus.flush = 1'b0;
        drive(1'b0, '0, '0);
        n_tests++; if (bus.trig_valid !== 1'b0) begin n_fail++; $display("FAIL flush_tv got %b want 0", bus.trig_valid); end
        n_tests++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", bus.count); end
        n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", bus.cmd_ready); end
        for (int i = 0; i < 35; i++) begin
            bus.qclk_in = 32'd311 + 32'(i);
            tick();
            n_tests++; if (bus.trig_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale qclk=%0d got %b want 0", bus.qclk_in, bus.trig_valid); end
        end
    endtask

    task automatic test_reset_mid();
        bus.qclk_in = 32'd390;
        drive(1'b1, 32'd400, 16'h0F0F); tick();
        drive(1'b1, 32'd401, 16'hF0F0); tick();
        drive(1'b0, '0, '0);
        n_tests++; if (bus.count !== 3'd2) begin n_fail++; $display("FAIL rmid_pre got %0d want 2", bus.count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (bus.count !== 3'd0 || bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_queue count=%0d ready=%b want 0/1", bus.count, bus.cmd_ready); end
        n_tests++; if (bus.trig_valid !== 1'b0 || bus.trig_data !== 16'h0) begin n_fail++; $display("FAIL rmid_trig got %b/%h want 0/0", bus.trig_valid, bus.trig_data); end
        n_tests++; if (bus.late_err !== 1'b0 || bus.late_flag !== 1'b0) begin n_fail++; $display("FAIL rmid_late got %b%b want 00", bus.late_err, bus.late_flag); end
        for (int i = 1; i < 16; i++) begin
            bus.qclk_in = 32'd390 + 32'(i);
            tick();
            n_tests++; if (bus.trig_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_fire qclk=%0d got %b want 0", bus.qclk_in, bus.trig_valid); end
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 80)      bus.qclk_in = bus.qclk_in + 32'd1;
            else if (r > 94) bus.qclk_in = bus.qclk_in + 32'($urandom_range(2, 4));
            drive(1'($urandom), bus.qclk_in + 32'($urandom_range(0, 10)) - 32'd2, 16'($urandom));
            bus.flush      = ($urandom_range(0, 99) < 3);
            bus.late_clear = ($urandom_range(0, 99) < 10);
            reset          = ($urandom_range(0, 199) == 0);
            tick();
            n_tests++; if (bus.trig_valid !== exp_tv) begin n_fail++; $display("FAIL rand_tv cyc=%0d got %b want %b", i, bus.trig_valid, exp_tv); end
            n_tests++; if (bus.trig_data !== exp_td) begin n_fail++; $display("FAIL rand_td cyc=%0d got %h want %h", i, bus.trig_data, exp_td); end
            n_tests++; if (bus.count !== 3'(q.size())) begin n_fail++; $display("FAIL rand_count cyc=%0d got %0d want %0d", i, bus.count, q.size()); end
            n_tests++; if (bus.cmd_ready !== (q.size() != DEPTH)) begin n_fail++; $display("FAIL rand_ready cyc=%0d got %b want %b", i, bus.cmd_ready, q.size() != DEPTH); end
            n_tests++; if (bus.late_err !== exp_le) begin n_fail++; $display("FAIL rand_le cyc=%0d got %b want %b", i, bus.late_err, exp_le); end
            n_tests++; if (bus.late_flag !== exp_lf) begin n_fail++; $display("FAIL rand_lf cyc=%0d got %b want %b", i, bus.late_flag, exp_lf); end
        end
        reset = 1'b0;
        bus.flush = 1'b0;
        bus.late_clear = 1'b0;
        drive(1'b0, '0, '0);
    endtask

    initial begin
        bus.qclk_in    = '0;
        bus.flush      = 1'b0;
        bus.late_clear = 1'b0;
        drive(1'b0, '0, '0);
        test_reset();
        test_single();
        test_full();
        test_wrap();
        test_late();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
